// File: rtl/kernel_dram_loader_pkg.sv
// Shared types and default widths for the DRAM-to-kernel-memory loader.
package kernel_dram_loader_pkg;

  localparam int DRAM_DATA_BITS = 512;
  localparam int DRAM_ADDR_BITS = 29;
  localparam int KER_NUM_DEF        = 3;
  localparam int KER_WIDTH_DEF      = 75;
  localparam int KER_HEIGHT_MAX_DEF = 1920;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  // A refill only happens once fewer than one line remains, so one word
  // plus a partial line is the most the buffer ever holds.
  function automatic int buf_bits(input int data_bits, input int ker_width);
    return data_bits + ker_width - 1;
  endfunction

endpackage

// File: rtl/kernel_dram_loader_bit_unpacker.sv
// Shift buffer that accepts whole DRAM words LSB-first and emits fixed-width
// kernel lines from its low end.
module kernel_dram_loader_bit_unpacker
  import kernel_dram_loader_pkg::*;
#(
  parameter int DATA_BITS = DRAM_DATA_BITS,
  parameter int KER_WIDTH = KER_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_pop,
  output logic [KER_WIDTH-1:0] o_line,
  output logic                 o_have_line,
  output logic                 o_have_next
);

  localparam int BW    = buf_bits(DATA_BITS, KER_WIDTH);
  localparam int CNT_W = $clog2(BW + 1);

  logic [BW-1:0]    r_buf;
  logic [CNT_W-1:0] r_bit_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf     <= '0;
      r_bit_cnt <= '0;
    end else if (i_clear) begin
      r_buf     <= '0;
      r_bit_cnt <= '0;
    end else if (i_load) begin
      r_buf     <= r_buf | (BW'(i_data) << r_bit_cnt);
      r_bit_cnt <= r_bit_cnt + CNT_W'(DATA_BITS);
    end else if (i_pop) begin
      r_buf     <= r_buf >> KER_WIDTH;
      r_bit_cnt <= r_bit_cnt - CNT_W'(KER_WIDTH);
    end
  end

  assign o_line      = r_buf[KER_WIDTH-1:0];
  assign o_have_line = (r_bit_cnt >= CNT_W'(KER_WIDTH));
  assign o_have_next = (r_bit_cnt >= CNT_W'(2 * KER_WIDTH));

endmodule

// File: rtl/kernel_dram_loader.sv
// Reads packed kernel lines from DRAM one word at a time and writes them,
// one line per cycle, into the selected kernel memory.
module kernel_dram_loader
  import kernel_dram_loader_pkg::*;
#(
  parameter int DATA_BITS      = DRAM_DATA_BITS,
  parameter int ADDR_BITS      = DRAM_ADDR_BITS,
  parameter int KER_NUM        = KER_NUM_DEF,
  parameter int KER_WIDTH      = KER_WIDTH_DEF,
  parameter int KER_HEIGHT_MAX = KER_HEIGHT_MAX_DEF,
  localparam int SEL_W         = $clog2(KER_NUM),
  localparam int LINES_W       = $clog2(KER_HEIGHT_MAX + 1),
  localparam int WADDR_W       = $clog2(KER_HEIGHT_MAX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SEL_W-1:0]     ker_sel,
  input  logic [ADDR_BITS-1:0] dram_base,
  input  logic [LINES_W-1:0]   ker_lines,
  output logic                 busy,
  output logic                 done,
  output logic                 dram_rd_req,
  output logic [ADDR_BITS-1:0] dram_rd_addr,
  input  logic                 dram_rd_ack,
  input  logic                 dram_rd_valid,
  input  logic [DATA_BITS-1:0] dram_rd_data,
  output logic [KER_NUM-1:0]   ker_wr_en,
  output logic [WADDR_W-1:0]   ker_wr_addr,
  output logic [KER_WIDTH-1:0] ker_wr_data
);

  state_t r_state, w_next;

  logic [SEL_W-1:0]     r_sel;
  logic [ADDR_BITS-1:0] r_base;
  logic [LINES_W-1:0]   r_lines;
  logic [ADDR_BITS-1:0] r_word_cnt;
  logic [LINES_W-1:0]   r_line_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [KER_NUM-1:0]   r_wr_en;
  logic [WADDR_W-1:0]   r_wr_addr;
  logic [KER_WIDTH-1:0] r_wr_data;

  logic                 w_clear, w_load, w_pop;
  logic                 w_have_line, w_have_next;
  logic [KER_WIDTH-1:0] w_line;
  logic [KER_NUM-1:0]   w_onehot;

  assign w_clear = (r_state == S_IDLE) && start;
  assign w_load  = (r_state == S_WAIT) && dram_rd_valid;
  assign w_pop   = (r_state == S_DRAIN) && w_have_line && (r_line_cnt < r_lines);

  kernel_dram_loader_bit_unpacker #(
    .DATA_BITS (DATA_BITS),
    .KER_WIDTH (KER_WIDTH)
  ) u_unpacker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_load      (w_load),
    .i_data      (dram_rd_data),
    .i_pop       (w_pop),
    .o_line      (w_line),
    .o_have_line (w_have_line),
    .o_have_next (w_have_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = (ker_lines == '0) ? S_DONE : S_REQ;
      S_REQ:   if (dram_rd_ack) w_next = S_WAIT;
      S_WAIT:  if (dram_rd_valid) w_next = S_DRAIN;
      S_DRAIN: begin
        if (w_pop) begin
          if (r_line_cnt + LINES_W'(1) == r_lines) w_next = S_DONE;
          else if (!w_have_next)                   w_next = S_REQ;
        end else if (r_line_cnt >= r_lines) begin
          w_next = S_DONE;
        end else begin
          w_next = S_REQ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Out-of-range selects decode to no enable, so the transfer still runs.
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < KER_NUM; k++) w_onehot[k] = (r_sel == SEL_W'(k));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel      <= '0;
      r_base     <= '0;
      r_lines    <= '0;
      r_word_cnt <= '0;
      r_line_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_en    <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_busy  <= (r_state != S_IDLE) || w_clear;
      r_done  <= (r_state == S_DONE);
      r_wr_en <= w_pop ? w_onehot : '0;
      if (w_clear) begin
        r_sel      <= ker_sel;
        r_base     <= dram_base;
        r_lines    <= ker_lines;
        r_word_cnt <= '0;
        r_line_cnt <= '0;
      end
      if (w_load) r_word_cnt <= r_word_cnt + ADDR_BITS'(1);
      if (w_pop) begin
        r_wr_addr  <= r_line_cnt[WADDR_W-1:0];
        r_wr_data  <= w_line;
        r_line_cnt <= r_line_cnt + LINES_W'(1);
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign dram_rd_req  = (r_state == S_REQ);
  assign dram_rd_addr = r_base + r_word_cnt;
  assign ker_wr_en    = r_wr_en;
  assign ker_wr_addr  = r_wr_addr;
  assign ker_wr_data  = r_wr_data;

endmodule

// File: tb/tb_kernel_dram_loader.sv
// Directed bench for kernel_dram_loader: DRAM responder tasks, a write
// monitor, and expected lines extracted bit by bit from the packed stream.
module tb_kernel_dram_loader;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [1:0]   ker_sel;
  logic [28:0]  dram_base;
  logic [10:0]  ker_lines;
  logic         busy, done, dram_rd_req;
  logic [28:0]  dram_rd_addr;
  logic         dram_rd_ack, dram_rd_valid;
  logic [511:0] dram_rd_data;
  logic [2:0]   ker_wr_en;
  logic [10:0]  ker_wr_addr;
  logic [74:0]  ker_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  en;
    logic [10:0] addr;
    logic [74:0] data;
  } wr_t;

  wr_t wq[$];
  int  done_cnt   = 0;
  int  busy_gaps  = 0;
  bit  track_busy = 1'b0;

  kernel_dram_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .ker_sel       (ker_sel),
    .dram_base     (dram_base),
    .ker_lines     (ker_lines),
    .busy          (busy),
    .done          (done),
    .dram_rd_req   (dram_rd_req),
    .dram_rd_addr  (dram_rd_addr),
    .dram_rd_ack   (dram_rd_ack),
    .dram_rd_valid (dram_rd_valid),
    .dram_rd_data  (dram_rd_data),
    .ker_wr_en     (ker_wr_en),
    .ker_wr_addr   (ker_wr_addr),
    .ker_wr_data   (ker_wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (|ker_wr_en === 1'b1) wq.push_back('{ker_wr_en, ker_wr_addr, ker_wr_data});
    if (done === 1'b1) done_cnt++;
    if (track_busy && busy !== 1'b1) busy_gaps++;
  end

  function automatic logic [511:0] make_word(input int seed, input int k);
    logic [511:0] w;
    for (int j = 0; j < 16; j++)
      w[j*32 +: 32] = 32'h9E3779B9 * 32'(seed * 1000 + k * 16 + j + 1);
    return w;
  endfunction

  function automatic logic [74:0] exp_line(input int seed, input int i);
    logic [74:0]  l;
    logic [511:0] w;
    for (int b = 0; b < 75; b++) begin
      int pos;
      pos  = 75 * i + b;
      w    = make_word(seed, pos / 512);
      l[b] = w[pos % 512];
    end
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] sel, input logic [28:0] base, input logic [10:0] lines);
    start     = 1'b1;
    ker_sel   = sel;
    dram_base = base;
    ker_lines = lines;
    step();
    start = 1'b0;
  endtask

  // Waits for a request, checks it is held until ack, then returns one word.
  task automatic serve(input logic [28:0] exp_addr, input int ack_delay,
                       input bit spurious, input logic [511:0] data);
    int t;
    t = 0;
    while (dram_rd_req !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    check("req_seen", dram_rd_req, 1);
    if (dram_rd_req !== 1'b1) return;
    check("rd_addr", dram_rd_addr, exp_addr);
    for (int d = 0; d < ack_delay; d++) begin
      if (spurious && d == 1) begin
        dram_rd_valid = 1'b1;
        dram_rd_data  = ~data;
      end
      step();
      dram_rd_valid = 1'b0;
      dram_rd_data  = '0;
      check("req_hold", dram_rd_req, 1);
      check("addr_hold", dram_rd_addr, exp_addr);
    end
    dram_rd_ack = 1'b1;
    step();
    dram_rd_ack = 1'b0;
    check("req_drop_after_ack", dram_rd_req, 0);
    dram_rd_valid = 1'b1;
    dram_rd_data  = data;
    step();
    dram_rd_valid = 1'b0;
    dram_rd_data  = '0;
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (done !== 1'b1 && t < budget) begin
      step();
      t++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic check_writes(input string tag, input int first, input int n,
                              input logic [2:0] en, input int seed);
    check({tag, "_count"}, wq.size() - first, n);
    for (int i = 0; i < n; i++) begin
      if (first + i < wq.size()) begin
        check($sformatf("%s_en%0d", tag, i), wq[first+i].en, en);
        check($sformatf("%s_addr%0d", tag, i), wq[first+i].addr, i);
        check($sformatf("%s_data%0d", tag, i), wq[first+i].data, exp_line(seed, i));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_req"}, dram_rd_req, 0);
    check({tag, "_addr"}, dram_rd_addr, 0);
    check({tag, "_wr_en"}, ker_wr_en, 0);
    check({tag, "_wr_addr"}, ker_wr_addr, 0);
    check({tag, "_wr_data"}, ker_wr_data, 0);
  endtask

  // Six lines from one word into memory 0, including first-write latency.
  task automatic run_six_lines(input string tag);
    int q0, d0;
    q0 = wq.size();
    d0 = done_cnt;
    do_start(2'd0, 29'h100, 11'd6);
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_req_after_start"}, dram_rd_req, 1);
    serve(29'h100, 0, 1'b0, make_word(0, 0));
    check({tag, "_no_write_yet"}, ker_wr_en, 0);
    step();
    check({tag, "_first_write_en"}, ker_wr_en, 3'b001);
    wait_done(50);
    step();
    check({tag, "_busy_after_done"}, busy, 0);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check_writes(tag, q0, 6, 3'b001, 0);
  endtask

  initial begin
    int q0, d0;
    logic [511:0] w0, w1;
    rst_n = 1'b0; start = 1'b0; ker_sel = '0; dram_base = '0; ker_lines = '0;
    dram_rd_ack = 1'b0; dram_rd_valid = 1'b0; dram_rd_data = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    run_six_lines("six");
    step();

    // Seven lines into memory 1; line 6 straddles the word boundary and the
    // second address wraps past the top of the DRAM address space.
    q0 = wq.size();
    w0 = make_word(1, 0);
    w1 = make_word(1, 1);
    do_start(2'd1, 29'h1FFF_FFFF, 11'd7);
    serve(29'h1FFF_FFFF, 1, 1'b0, w0);
    serve(29'h0, 0, 1'b0, w1);
    wait_done(50);
    check_writes("seven", q0, 7, 3'b010, 1);
    if (wq.size() >= q0 + 7)
      check("seven_line6_split", wq[q0+6].data, {w1[12:0], w0[511:450]});
    step();

    // 96 lines into memory 2: 15 words, one with a slow ack and a stray valid.
    q0 = wq.size();
    d0 = done_cnt;
    do_start(2'd2, 29'h1000, 11'd96);
    track_busy = 1'b1;
    for (int k = 0; k < 15; k++)
      serve(29'h1000 + 29'(k), (k == 4) ? 5 : k % 3, k == 4, make_word(2, k));
    wait_done(100);
    track_busy = 1'b0;
    step();
    check("big_busy_gaps", busy_gaps, 0);
    check("big_done_once", done_cnt - d0, 1);
    check_writes("big", q0, 96, 3'b100, 2);

    // Zero lines: no read, done two cycles after start, restart ignored.
    d0 = done_cnt;
    do_start(2'd0, 29'h300, 11'd0);
    check("zero_busy", busy, 1);
    check("zero_no_done_yet", done, 0);
    check("zero_no_req", dram_rd_req, 0);
    start = 1'b1; ker_lines = 11'd6;
    step();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy_at_done", busy, 1);
    step();
    check("zero_done_drop", done, 0);
    check("zero_busy_drop", busy, 0);
    repeat (4) step();
    check("zero_restart_ignored_req", dram_rd_req, 0);
    check("zero_restart_ignored_busy", busy, 0);
    check("zero_done_once", done_cnt - d0, 1);

    // Out-of-range select: transfer completes with no enables.
    q0 = wq.size();
    do_start(2'd3, 29'h200, 11'd6);
    serve(29'h200, 0, 1'b0, make_word(3, 0));
    wait_done(50);
    check("badsel_no_writes", wq.size() - q0, 0);
    step();

    // Reset during DRAIN, then a late valid, then a clean rerun.
    do_start(2'd0, 29'h40, 11'd7);
    serve(29'h40, 0, 1'b0, make_word(4, 0));
    step();
    step();
    rst_n = 1'b0;
    step();
    check_idle_outputs("midreset");
    q0 = wq.size();
    rst_n = 1'b1;
    dram_rd_valid = 1'b1;
    dram_rd_data  = make_word(4, 1);
    step();
    dram_rd_valid = 1'b0;
    dram_rd_data  = '0;
    repeat (4) step();
    check("midreset_no_late_write", wq.size() - q0, 0);
    check("midreset_no_req", dram_rd_req, 0);
    check("midreset_idle", busy, 0);
    run_six_lines("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
